// File: rtl/fsgnj_s_unit.sv
// Single-precision sign injection (FSGNJ.S / FSGNJN.S / FSGNJX.S).
// Combinational result plus a registered copy with a valid flag for the pipelined issue path.
module fsgnj_s_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic [1:0]  op,
  input  logic        valid_in,
  output logic [31:0] y,
  output logic [31:0] y_q,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    OP_SGNJ  = 2'b00,
    OP_SGNJN = 2'b01,
    OP_SGNJX = 2'b10,
    OP_RSVD  = 2'b11
  } sgnj_op_e;

  logic sign_sel;

  // Reserved encoding falls through to plain FSGNJ.
  always_comb begin
    sign_sel = x2[31];
    case (sgnj_op_e'(op))
      OP_SGNJN: sign_sel = ~x2[31];
      OP_SGNJX: sign_sel = x1[31] ^ x2[31];
      default:  sign_sel = x2[31];
    endcase
  end

  // Magnitude passes through untouched, NaN payloads included.
  assign y = {sign_sel, x1[30:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= 32'h0000_0000;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        y_q <= y;
      end
    end
  end

endmodule

// File: tb/tb_fsgnj_s_unit.sv
// Directed self-checking bench for fsgnj_s_unit: combinational sign injection,
// registered path latency/hold, asynchronous reset and clock-independent y.
module tb_fsgnj_s_unit;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [1:0]  op;
  logic        valid_in;
  logic [31:0] y;
  logic [31:0] y_q;
  logic        valid_out;

  int checks;
  int failures;

  fsgnj_s_unit dut (
    .clk       (clk),
    .rst       (rst),
    .x1        (x1),
    .x2        (x2),
    .op        (op),
    .valid_in  (valid_in),
    .y         (y),
    .y_q       (y_q),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic test_reset();
    #1;
    checks++;
    if (y_q !== 32'h0000_0000) begin
      failures++;
      $display("FAIL reset_y_q got=%h want=%h", y_q, 32'h0);
    end
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_out got=%b want=0", valid_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fsgnj_directed();
    logic [31:0] tx1 [6];
    logic [31:0] tx2 [6];
    logic [31:0] ty  [6];
    tx1[0] = 32'h3F80_0000; tx2[0] = 32'hC000_0000; ty[0] = 32'hBF80_0000;
    tx1[1] = 32'h0000_0000; tx2[1] = 32'h8000_0000; ty[1] = 32'h8000_0000;
    tx1[2] = 32'h8000_0000; tx2[2] = 32'h0000_0000; ty[2] = 32'h0000_0000;
    tx1[3] = 32'h7FC0_0001; tx2[3] = 32'h8000_0000; ty[3] = 32'hFFC0_0001;
    tx1[4] = 32'h7F80_0000; tx2[4] = 32'hFFFF_FFFF; ty[4] = 32'hFF80_0000;
    tx1[5] = 32'h8000_0001; tx2[5] = 32'h7FFF_FFFF; ty[5] = 32'h0000_0001;
    op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      x1 = tx1[i];
      x2 = tx2[i];
      #1;
      checks++;
      if (y !== ty[i]) begin
        failures++;
        $display("FAIL fsgnj_vec%0d got=%h want=%h", i, y, ty[i]);
      end
    end
  endtask

  task automatic test_fsgnj_random();
    logic [31:0] exp_y;
    op = 2'b00;
    for (int i = 0; i < 200; i++) begin
      x1 = $urandom;
      x2 = $urandom;
      exp_y = {x2[31], x1[30:0]};
      #1;
      checks++;
      if (y !== exp_y) begin
        failures++;
        $display("FAIL fsgnj_rand%0d x1=%h x2=%h got=%h want=%h", i, x1, x2, y, exp_y);
      end
    end
  endtask

  task automatic test_fsgnjn_fsgnjx();
    logic [1:0]  top [6];
    logic [31:0] tx1 [6];
    logic [31:0] tx2 [6];
    logic [31:0] ty  [6];
    top[0] = 2'b01; tx1[0] = 32'h4049_0FDB; tx2[0] = 32'h0000_0000; ty[0] = 32'hC049_0FDB;
    top[1] = 2'b10; tx1[1] = 32'hC049_0FDB; tx2[1] = 32'h8000_0000; ty[1] = 32'h4049_0FDB;
    top[2] = 2'b01; tx1[2] = 32'hC049_0FDB; tx2[2] = 32'hFFC0_0000; ty[2] = 32'h4049_0FDB;
    top[3] = 2'b10; tx1[3] = 32'h4049_0FDB; tx2[3] = 32'h8000_0000; ty[3] = 32'hC049_0FDB;
    top[4] = 2'b10; tx1[4] = 32'h7FC0_0001; tx2[4] = 32'h7FFF_FFFF; ty[4] = 32'h7FC0_0001;
    top[5] = 2'b01; tx1[5] = 32'h0000_0000; tx2[5] = 32'h7F80_0001; ty[5] = 32'h8000_0000;
    for (int i = 0; i < 6; i++) begin
      op = top[i];
      x1 = tx1[i];
      x2 = tx2[i];
      #1;
      checks++;
      if (y !== ty[i]) begin
        failures++;
        $display("FAIL sgnjn_x_vec%0d op=%b got=%h want=%h", i, op, y, ty[i]);
      end
    end
  endtask

  task automatic test_reserved_op();
    op = 2'b11;
    x1 = 32'h3F80_0000;
    x2 = 32'hC000_0000;
    #1;
    checks++;
    if (y !== 32'hBF80_0000) begin
      failures++;
      $display("FAIL reserved_op_a got=%h want=%h", y, 32'hBF80_0000);
    end
    x1 = 32'hBF80_0000;
    x2 = 32'h0000_0000;
    #1;
    checks++;
    if (y !== 32'h3F80_0000) begin
      failures++;
      $display("FAIL reserved_op_b got=%h want=%h", y, 32'h3F80_0000);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  top [3];
    logic [31:0] tx1 [3];
    logic [31:0] tx2 [3];
    logic [31:0] ty  [3];
    top[0] = 2'b00; tx1[0] = 32'h3F80_0000; tx2[0] = 32'hC000_0000; ty[0] = 32'hBF80_0000;
    top[1] = 2'b01; tx1[1] = 32'h4049_0FDB; tx2[1] = 32'h0000_0000; ty[1] = 32'hC049_0FDB;
    top[2] = 2'b10; tx1[2] = 32'hC049_0FDB; tx2[2] = 32'h8000_0000; ty[2] = 32'h4049_0FDB;
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL pipe_idle_valid got=%b want=0", valid_out);
    end
    for (int i = 0; i < 3; i++) begin
      op = top[i];
      x1 = tx1[i];
      x2 = tx2[i];
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (y_q !== ty[i] || valid_out !== 1'b1) begin
        failures++;
        $display("FAIL pipe_beat%0d y_q=%h valid_out=%b want y_q=%h valid_out=1", i, y_q, valid_out, ty[i]);
      end
    end
    valid_in = 1'b0;
    x1 = 32'h1234_5678;
    x2 = 32'h8000_0000;
    op = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (y_q !== ty[2] || valid_out !== 1'b0) begin
        failures++;
        $display("FAIL pipe_hold%0d y_q=%h valid_out=%b want y_q=%h valid_out=0", i, y_q, valid_out, ty[2]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    op = 2'b00;
    x1 = 32'h4000_0000;
    x2 = 32'h8000_0000;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b1 || y_q !== 32'hC000_0000) begin
      failures++;
      $display("FAIL arst_pre valid_out=%b y_q=%h want 1 %h", valid_out, y_q, 32'hC000_0000);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (y_q !== 32'h0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL arst_immediate y_q=%h valid_out=%b want 0 0", y_q, valid_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (y_q !== 32'h0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL arst_held y_q=%h valid_out=%b want 0 0", y_q, valid_out);
    end
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b0) begin
      failures++;
      $display("FAIL arst_after_release valid_out=%b want 0", valid_out);
    end
    @(negedge clk);
    x1 = 32'h4049_0FDB;
    x2 = 32'h8000_0000;
    op = 2'b00;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== 1'b1 || y_q !== 32'hC049_0FDB) begin
      failures++;
      $display("FAIL arst_first_valid valid_out=%b y_q=%h want 1 %h", valid_out, y_q, 32'hC049_0FDB);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic test_comb_independence();
    logic [1:0]  top [3];
    logic [31:0] tx1 [3];
    logic [31:0] tx2 [3];
    logic [31:0] ty  [3];
    top[0] = 2'b00; tx1[0] = 32'h3F80_0000; tx2[0] = 32'h8000_0000; ty[0] = 32'hBF80_0000;
    top[1] = 2'b01; tx1[1] = 32'hFF80_0000; tx2[1] = 32'h8000_0000; ty[1] = 32'h7F80_0000;
    top[2] = 2'b10; tx1[2] = 32'h8000_0001; tx2[2] = 32'h0000_0000; ty[2] = 32'h8000_0001;
    @(negedge clk);
    rst = 1'b1;
    clk_en = 1'b0;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = top[i];
      x1 = tx1[i];
      x2 = tx2[i];
      #3;
      checks++;
      if (y !== ty[i]) begin
        failures++;
        $display("FAIL comb_in_reset%0d got=%h want=%h", i, y, ty[i]);
      end
    end
    checks++;
    if (y_q !== 32'h0 || valid_out !== 1'b0) begin
      failures++;
      $display("FAIL comb_regs_in_reset y_q=%h valid_out=%b want 0 0", y_q, valid_out);
    end
    valid_in = 1'b0;
    clk_en = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b1;
    rst      = 1'b1;
    x1       = 32'h0;
    x2       = 32'h0;
    op       = 2'b00;
    valid_in = 1'b0;
    test_reset();
    test_fsgnj_directed();
    test_fsgnj_random();
    test_fsgnjn_fsgnjx();
    test_reserved_op();
    test_back_to_back();
    test_async_reset();
    test_comb_independence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
